// File: rtl/ex_mdu_pkg.sv
// Shared opcode/result-class constants and divider state encoding for ex_mdu.
// Used by ex_mdu and, when EX_MDU_DIV_EN is defined, ex_mdu_div.
package ex_mdu_pkg;

  localparam int unsigned ALU_OP_W  = 8;
  localparam int unsigned ALU_SEL_W = 3;

  localparam logic [ALU_OP_W-1:0] EXE_NOP_OP  = 8'b0000_0000;
  localparam logic [ALU_OP_W-1:0] EXE_AND_OP  = 8'b0010_0100;
  localparam logic [ALU_OP_W-1:0] EXE_OR_OP   = 8'b0010_0101;
  localparam logic [ALU_OP_W-1:0] EXE_XOR_OP  = 8'b0010_0110;
  localparam logic [ALU_OP_W-1:0] EXE_NOR_OP  = 8'b0010_0111;
  localparam logic [ALU_OP_W-1:0] EXE_SLL_OP  = 8'b0111_1100;
  localparam logic [ALU_OP_W-1:0] EXE_SRL_OP  = 8'b0000_0010;
  localparam logic [ALU_OP_W-1:0] EXE_SRA_OP  = 8'b0000_0011;
  localparam logic [ALU_OP_W-1:0] EXE_ADDU_OP = 8'b0010_0001;
  localparam logic [ALU_OP_W-1:0] EXE_SUBU_OP = 8'b0010_0011;
  localparam logic [ALU_OP_W-1:0] EXE_SLT_OP  = 8'b0010_1010;
  localparam logic [ALU_OP_W-1:0] EXE_SLTU_OP = 8'b0010_1011;
  localparam logic [ALU_OP_W-1:0] EXE_MFHI_OP = 8'b0001_0000;
  localparam logic [ALU_OP_W-1:0] EXE_MTHI_OP = 8'b0001_0001;
  localparam logic [ALU_OP_W-1:0] EXE_MFLO_OP = 8'b0001_0010;
  localparam logic [ALU_OP_W-1:0] EXE_MTLO_OP = 8'b0001_0011;
  localparam logic [ALU_OP_W-1:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [ALU_OP_W-1:0] EXE_DIVU_OP = 8'b0001_1011;

  localparam logic [ALU_SEL_W-1:0] EXE_RES_NOP   = 3'b000;
  localparam logic [ALU_SEL_W-1:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [ALU_SEL_W-1:0] EXE_RES_SHIFT = 3'b010;
  localparam logic [ALU_SEL_W-1:0] EXE_RES_MOVE  = 3'b011;
  localparam logic [ALU_SEL_W-1:0] EXE_RES_ARITH = 3'b100;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  function automatic logic is_div(input logic [ALU_OP_W-1:0] op);
    return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
  endfunction

endpackage

// File: rtl/ex_mdu_div.sv
// Iterative restoring divider (signed/unsigned) with start/annul/done handshake.
// Instantiated by ex_mdu only when EX_MDU_DIV_EN is defined.
module ex_mdu_div
  import ex_mdu_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              signed_op,
  input  logic              annul,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              stall_c,
  output logic              done_c,
  output logic [DATA_W-1:0] quotient_c,
  output logic [DATA_W-1:0] remainder_c
);

  localparam int unsigned CNT_W = $clog2(DATA_W) + 1;

  div_state_e        state, state_n;
  logic [CNT_W-1:0]  count, count_n;
  logic [DATA_W-1:0] dq, dq_n, rem, rem_n, dvs, dvs_n;
  logic              neg_q, neg_q_n, neg_r, neg_r_n;
  logic              neg_a, neg_b;
  logic [DATA_W-1:0] mag_a, mag_b;
  logic [DATA_W:0]   trial;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DIV_IDLE;
      count <= '0;
      dq    <= '0;
      rem   <= '0;
      dvs   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      state <= state_n;
      count <= count_n;
      dq    <= dq_n;
      rem   <= rem_n;
      dvs   <= dvs_n;
      neg_q <= neg_q_n;
      neg_r <= neg_r_n;
    end
  end

  // Next state, one restoring step per BUSY cycle, and handshake outputs.
  always_comb begin
    state_n = state;
    count_n = count;
    dq_n    = dq;
    rem_n   = rem;
    dvs_n   = dvs;
    neg_q_n = neg_q;
    neg_r_n = neg_r;
    stall_c = 1'b0;
    done_c  = 1'b0;

    neg_a = signed_op & dividend[DATA_W-1];
    neg_b = signed_op & divisor[DATA_W-1];
    mag_a = neg_a ? -dividend : dividend;
    mag_b = neg_b ? -divisor : divisor;
    trial = {rem, dq[DATA_W-1]} - {1'b0, dvs};

    case (state)
      DIV_IDLE: begin
        if (start) begin
          stall_c = 1'b1;
          count_n = '0;
          rem_n   = '0;
          dvs_n   = mag_b;
          if (divisor == '0) begin
            dq_n    = '0;
            neg_q_n = 1'b0;
            neg_r_n = 1'b0;
            state_n = DIV_DONE;
          end else begin
            dq_n    = mag_a;
            neg_q_n = neg_a ^ neg_b;
            neg_r_n = neg_a;
            state_n = DIV_BUSY;
          end
        end
      end
      DIV_BUSY: begin
        stall_c = 1'b1;
        count_n = count + 1'b1;
        if (!trial[DATA_W]) begin
          rem_n = trial[DATA_W-1:0];
          dq_n  = {dq[DATA_W-2:0], 1'b1};
        end else begin
          rem_n = {rem[DATA_W-2:0], dq[DATA_W-1]};
          dq_n  = {dq[DATA_W-2:0], 1'b0};
        end
        if (count == CNT_W'(DATA_W - 1)) state_n = DIV_DONE;
      end
      DIV_DONE: begin
        done_c  = 1'b1;
        state_n = DIV_IDLE;
      end
      default: state_n = DIV_IDLE;
    endcase

    // A flush kills the divide outright: no hold, no HI/LO write.
    if (annul) begin
      state_n = DIV_IDLE;
      stall_c = 1'b0;
      done_c  = 1'b0;
    end

    quotient_c  = neg_q ? -dq : dq;
    remainder_c = neg_r ? -rem : rem;
  end

endmodule

// File: rtl/ex_mdu.sv
// Execute stage: logic/shift/arith/move result classes plus optional iterative
// divider writing HI/LO; the divider is built only when EX_MDU_DIV_EN is defined.
module ex_mdu
  import ex_mdu_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ALU_OP_W-1:0]  aluop_i,
  input  logic [ALU_SEL_W-1:0] alusel_i,
  input  logic [DATA_W-1:0]    reg1_i,
  input  logic [DATA_W-1:0]    reg2_i,
  input  logic [REG_AW-1:0]    wd_i,
  input  logic                 wreg_i,
  input  logic [DATA_W-1:0]    hi_i,
  input  logic [DATA_W-1:0]    lo_i,
  input  logic                 annul_i,
  output logic [REG_AW-1:0]    wd_o,
  output logic                 wreg_o,
  output logic [DATA_W-1:0]    wdata_o,
  output logic                 whilo_o,
  output logic [DATA_W-1:0]    hi_o,
  output logic [DATA_W-1:0]    lo_o,
  output logic                 stallreq_o
);

  localparam int unsigned SH_W = $clog2(DATA_W);

  logic [SH_W-1:0]   shamt;
  logic [DATA_W-1:0] logic_res, shift_res, arith_res, move_res, result;
  logic              div_stall, div_done;
  logic [DATA_W-1:0] div_q, div_r;

  assign shamt = reg1_i[SH_W-1:0];

  // Per-class results; anything unrecognised inside a class yields zero.
  always_comb begin
    logic_res = '0;
    shift_res = '0;
    arith_res = '0;
    move_res  = '0;
    case (aluop_i)
      EXE_OR_OP:   logic_res = reg1_i | reg2_i;
      EXE_AND_OP:  logic_res = reg1_i & reg2_i;
      EXE_XOR_OP:  logic_res = reg1_i ^ reg2_i;
      EXE_NOR_OP:  logic_res = ~(reg1_i | reg2_i);
      default:     logic_res = '0;
    endcase
    case (aluop_i)
      EXE_SLL_OP:  shift_res = reg2_i << shamt;
      EXE_SRL_OP:  shift_res = reg2_i >> shamt;
      EXE_SRA_OP:  shift_res = DATA_W'($signed(reg2_i) >>> shamt);
      default:     shift_res = '0;
    endcase
    case (aluop_i)
      EXE_ADDU_OP: arith_res = reg1_i + reg2_i;
      EXE_SUBU_OP: arith_res = reg1_i - reg2_i;
      EXE_SLT_OP:  arith_res = DATA_W'($signed(reg1_i) < $signed(reg2_i));
      EXE_SLTU_OP: arith_res = DATA_W'(reg1_i < reg2_i);
      default:     arith_res = '0;
    endcase
    case (aluop_i)
      EXE_MFHI_OP: move_res = hi_i;
      EXE_MFLO_OP: move_res = lo_i;
      default:     move_res = '0;
    endcase
  end

  always_comb begin
    case (alusel_i)
      EXE_RES_LOGIC: result = logic_res;
      EXE_RES_SHIFT: result = shift_res;
      EXE_RES_ARITH: result = arith_res;
      EXE_RES_MOVE:  result = move_res;
      default:       result = '0;
    endcase
  end

`ifdef EX_MDU_DIV_EN
  ex_mdu_div #(
    .DATA_W(DATA_W)
  ) u_div (
    .clk         (clk),
    .rst         (rst),
    .start       (is_div(aluop_i)),
    .signed_op   (aluop_i == EXE_DIV_OP),
    .annul       (annul_i),
    .dividend    (reg1_i),
    .divisor     (reg2_i),
    .stall_c     (div_stall),
    .done_c      (div_done),
    .quotient_c  (div_q),
    .remainder_c (div_r)
  );
`else
  logic unused_div;
  assign unused_div = ^{clk, annul_i};
  assign div_stall  = 1'b0;
  assign div_done   = 1'b0;
  assign div_q      = '0;
  assign div_r      = '0;
`endif

  // Output mux: divider completion owns HI/LO; reset forces every output low.
  always_comb begin
    wd_o       = wd_i;
    wreg_o     = wreg_i;
    wdata_o    = result;
    whilo_o    = 1'b0;
    hi_o       = '0;
    lo_o       = '0;
    stallreq_o = div_stall;
    if (div_done) begin
      whilo_o = 1'b1;
      hi_o    = div_r;
      lo_o    = div_q;
    end else if (aluop_i == EXE_MTHI_OP) begin
      whilo_o = 1'b1;
      hi_o    = reg1_i;
      lo_o    = lo_i;
    end else if (aluop_i == EXE_MTLO_OP) begin
      whilo_o = 1'b1;
      hi_o    = hi_i;
      lo_o    = reg1_i;
    end
    if (rst) begin
      wd_o       = '0;
      wreg_o     = 1'b0;
      wdata_o    = '0;
      whilo_o    = 1'b0;
      hi_o       = '0;
      lo_o       = '0;
      stallreq_o = 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_mdu.sv
// Scoreboard bench for ex_mdu: per-cycle expectations queued by the driver,
// popped and compared on the falling edge. Honours EX_MDU_DIV_EN.
module tb_ex_mdu;
  import ex_mdu_pkg::*;

  localparam int W  = 32;
  localparam int AW = 5;

  typedef struct {
    logic [W-1:0]  wdata;
    logic          whilo;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;
    logic          stall;
    logic [AW-1:0] wd;
    logic          wreg;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic annul = 1'b0;
  logic [7:0] aluop = 8'h00;
  logic [2:0] alusel = 3'd0;
  logic [W-1:0] reg1 = '0, reg2 = '0, hi = '0, lo = '0;
  logic [AW-1:0] wd = '0;
  logic wreg = 1'b0;

  logic [AW-1:0] wd_o;
  logic wreg_o, whilo_o, stallreq_o;
  logic [W-1:0] wdata_o, hi_o, lo_o;

  exp_t  exp_q[$];
  string name_q[$];
  int vectors = 0;
  int miscompares = 0;

  ex_mdu #(.DATA_W(W), .REG_AW(AW)) dut (
    .clk(clk), .rst(rst), .aluop_i(aluop), .alusel_i(alusel),
    .reg1_i(reg1), .reg2_i(reg2), .wd_i(wd), .wreg_i(wreg),
    .hi_i(hi), .lo_i(lo), .annul_i(annul),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .whilo_o(whilo_o),
    .hi_o(hi_o), .lo_o(lo_o), .stallreq_o(stallreq_o)
  );

  always #5 clk = ~clk;

  // Reference model for the single-cycle datapath
  function automatic exp_t comb_model(input logic [7:0] op, input logic [2:0] sel,
                                      input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic [W-1:0] h, input logic [W-1:0] l,
                                      input logic [AW-1:0] d, input logic we);
    exp_t e;
    int sh;
    logic [W-1:0] r;
    sh = int'(a[4:0]);
    r = '0;
    case (sel)
      EXE_RES_LOGIC:
        if (op == EXE_OR_OP) r = a | b;
        else if (op == EXE_AND_OP) r = a & b;
        else if (op == EXE_XOR_OP) r = a ^ b;
        else if (op == EXE_NOR_OP) r = ~(a | b);
      EXE_RES_SHIFT:
        if (op == EXE_SLL_OP) r = b << sh;
        else if (op == EXE_SRL_OP) r = b >> sh;
        else if (op == EXE_SRA_OP) begin
          r = b;
          for (int i = 0; i < sh; i++) r = {r[W-1], r[W-1:1]};
        end
      EXE_RES_ARITH:
        if (op == EXE_ADDU_OP) r = W'(longint'(a) + longint'(b));
        else if (op == EXE_SUBU_OP) r = W'(longint'(a) - longint'(b));
        else if (op == EXE_SLT_OP) r = (longint'($signed(a)) < longint'($signed(b))) ? 1 : 0;
        else if (op == EXE_SLTU_OP) r = (longint'(a) < longint'(b)) ? 1 : 0;
      EXE_RES_MOVE:
        if (op == EXE_MFHI_OP) r = h;
        else if (op == EXE_MFLO_OP) r = l;
      default: r = '0;
    endcase
    e.wdata = r; e.whilo = 1'b0; e.hi = '0; e.lo = '0; e.stall = 1'b0;
    e.wd = d; e.wreg = we;
    if (op == EXE_MTHI_OP) begin e.whilo = 1'b1; e.hi = a; e.lo = l; end
    if (op == EXE_MTLO_OP) begin e.whilo = 1'b1; e.hi = h; e.lo = a; end
    return e;
  endfunction

  function automatic exp_t cur_exp();
    exp_t z;
    z.wdata = '0; z.whilo = 1'b0; z.hi = '0; z.lo = '0; z.stall = 1'b0; z.wd = '0; z.wreg = 1'b0;
    if (rst) return z;
    return comb_model(aluop, alusel, reg1, reg2, hi, lo, wd, wreg);
  endfunction

  task automatic step(input string name, input exp_t e);
    exp_q.push_back(e);
    name_q.push_back(name);
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [7:0] op, input logic [2:0] sel,
                        input logic [W-1:0] a, input logic [W-1:0] b);
    aluop = op; alusel = sel; reg1 = a; reg2 = b;
    hi = $urandom; lo = $urandom; wd = AW'($urandom); wreg = 1'($urandom);
  endtask

  task automatic comb(input string name, input logic [7:0] op, input logic [2:0] sel,
                      input logic [W-1:0] a, input logic [W-1:0] b);
    set_in(op, sel, a, b);
    step(name, cur_exp());
  endtask

  // Divide: signed semantics from plain integer / and %, truncating toward zero
  task automatic do_div(input string name, input bit sgn, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int abort_at, input bit use_rst);
    exp_t e;
    longint qa, qb;
    logic [W-1:0] q, r;
    if (b == '0) begin
      q = '0; r = '0;
    end else if (sgn) begin
      qa = longint'($signed(a)); qb = longint'($signed(b));
      q = W'(qa / qb); r = W'(qa % qb);
    end else begin
      qa = longint'(a); qb = longint'(b);
      q = W'(qa / qb); r = W'(qa % qb);
    end
    set_in(sgn ? EXE_DIV_OP : EXE_DIVU_OP, EXE_RES_NOP, a, b);
`ifdef EX_MDU_DIV_EN
    e = cur_exp(); e.stall = 1'b1;
    step({name, "_accept"}, e);
    for (int k = 0; k < ((b == '0) ? 0 : W); k++) begin
      reg1 = $urandom; reg2 = $urandom; hi = $urandom; lo = $urandom;
      if (k == abort_at) begin
        if (use_rst) rst = 1'b1; else annul = 1'b1;
        step({name, "_abort"}, cur_exp());
        rst = 1'b0; annul = 1'b0;
        set_in(EXE_NOP_OP, EXE_RES_NOP, $urandom, $urandom);
        step({name, "_after_abort"}, cur_exp());
        return;
      end
      e = cur_exp(); e.stall = 1'b1;
      step({name, "_busy"}, e);
    end
    e = cur_exp(); e.whilo = 1'b1; e.hi = r; e.lo = q;
    step({name, "_done"}, e);
`else
    step({name, "_disabled"}, cur_exp());
    if (abort_at >= 0) begin
      if (use_rst) rst = 1'b1; else annul = 1'b1;
      set_in(EXE_NOP_OP, EXE_RES_NOP, q, r);
      step({name, "_abort"}, cur_exp());
      rst = 1'b0; annul = 1'b0;
    end
`endif
  endtask

  // Monitor: compare every presented cycle against the queued expectation
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      vectors++;
      if (wdata_o !== e.wdata || whilo_o !== e.whilo || hi_o !== e.hi || lo_o !== e.lo ||
          stallreq_o !== e.stall || wd_o !== e.wd || wreg_o !== e.wreg) begin
        miscompares++;
        $display("FAIL %s got/want: wdata=%h/%h whilo=%b/%b hi=%h/%h lo=%h/%h stall=%b/%b wd=%h/%h wreg=%b/%b",
                 n, wdata_o, e.wdata, whilo_o, e.whilo, hi_o, e.hi, lo_o, e.lo,
                 stallreq_o, e.stall, wd_o, e.wd, wreg_o, e.wreg);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] ops[17];
    logic [2:0] sels[17];
    logic [7:0] op;
    logic [2:0] sel;
    int idx;
    ops  = '{EXE_OR_OP, EXE_AND_OP, EXE_XOR_OP, EXE_NOR_OP, EXE_SLL_OP, EXE_SRL_OP,
             EXE_SRA_OP, EXE_ADDU_OP, EXE_SUBU_OP, EXE_SLT_OP, EXE_SLTU_OP,
             EXE_MFHI_OP, EXE_MFLO_OP, EXE_MTHI_OP, EXE_MTLO_OP, EXE_NOP_OP, 8'hFF};
    sels = '{EXE_RES_LOGIC, EXE_RES_LOGIC, EXE_RES_LOGIC, EXE_RES_LOGIC, EXE_RES_SHIFT,
             EXE_RES_SHIFT, EXE_RES_SHIFT, EXE_RES_ARITH, EXE_RES_ARITH, EXE_RES_ARITH,
             EXE_RES_ARITH, EXE_RES_MOVE, EXE_RES_MOVE, EXE_RES_MOVE, EXE_RES_MOVE,
             EXE_RES_NOP, EXE_RES_ARITH};

    @(posedge clk); #1;
    rst = 1'b1;
    comb("reset_mthi", EXE_MTHI_OP, EXE_RES_MOVE, 32'h1234, 32'h1);
    comb("reset_or", EXE_OR_OP, EXE_RES_LOGIC, 32'hFFFF_0000, 32'h00FF);
    rst = 1'b0;

    comb("sra", EXE_SRA_OP, EXE_RES_SHIFT, 32'h0000_0004, 32'h8000_00F0);
    comb("srl", EXE_SRL_OP, EXE_RES_SHIFT, 32'h0000_0004, 32'h8000_00F0);
    comb("or", EXE_OR_OP, EXE_RES_LOGIC, 32'h0000_0004, 32'h8000_00F0);
    comb("subu_wrap", EXE_SUBU_OP, EXE_RES_ARITH, 32'h0, 32'h1);
    comb("slt_neg", EXE_SLT_OP, EXE_RES_ARITH, 32'hFFFF_FFFF, 32'h1);
    comb("sltu_big", EXE_SLTU_OP, EXE_RES_ARITH, 32'hFFFF_FFFF, 32'h1);
    comb("sll_31", EXE_SLL_OP, EXE_RES_SHIFT, 32'h0000_001F, 32'h0000_0003);
    set_in(EXE_MTHI_OP, EXE_RES_MOVE, 32'h1234, 32'h0);
    lo = 32'hAA;
    step("mthi", cur_exp());
    set_in(EXE_MFLO_OP, EXE_RES_MOVE, 32'h0, 32'h0);
    lo = 32'hAA;
    step("mflo", cur_exp());

    for (int i = 0; i < 250; i++) begin
      idx = $urandom_range(0, 16);
      op  = ops[idx];
      sel = sels[idx];
      if ($urandom_range(0, 4) == 0) sel = 3'($urandom);
      if ($urandom_range(0, 9) == 0) op = 8'($urandom);
      if (is_div(op)) op = EXE_NOP_OP;
      comb("rand_op", op, sel, $urandom, $urandom);
    end

    do_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, -1, 1'b0);
    do_div("divu_ffff", 1'b0, 32'hFFFF_FFFF, 32'h10, -1, 1'b0);
    do_div("div_by_zero", 1'b1, 32'h1234_5678, 32'h0, -1, 1'b0);
    do_div("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0);
    do_div("div_annul", 1'b1, 32'd1000, 32'd7, 10, 1'b0);
    do_div("div_post_annul", 1'b1, 32'hFFFF_FC18, 32'd7, -1, 1'b0);
    do_div("div_rst", 1'b0, 32'd99999, 32'd13, 10, 1'b1);
    do_div("div_post_rst", 1'b0, 32'd99999, 32'd13, -1, 1'b0);
    for (int i = 0; i < 8; i++)
      do_div("div_rand", 1'($urandom), $urandom >> $urandom_range(0, 31),
             $urandom >> $urandom_range(0, 31), -1, 1'b0);
    comb("after_div", EXE_ADDU_OP, EXE_RES_ARITH, $urandom, $urandom);

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ex_mdu.md
# ex_mdu

Parametrised execute stage for the five-stage integer pipeline, sitting between the ID/EX and EX/MEM registers. It adds shift, arithmetic and HI/LO move result classes to the single-cycle logic datapath, and a multi-cycle iterative divider. The divider writes HI/LO and holds the pipeline through a stall request while it iterates.

## Interface
Parameters:
- DATA_W, 32, operand/result width; power of two, 8..64
- REG_AW, 5, destination register address width

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset (`RstEnable`); one clock; reset is synchronous and active-high
- aluop_i  in  `AluOpBus`  operation code
- alusel_i  in  `AluSelBus`  result class
- reg1_i, reg2_i  in  DATA_W  operands (reg1 = rs/dividend/shift amount, reg2 = rt/divisor/shift data)
- wd_i  in  REG_AW  destination register
- wreg_i  in  1  register write enable
- hi_i, lo_i  in  DATA_W  current HI/LO, already forwarded
- annul_i  in  1  flush; aborts the divide in flight
- wd_o  out  REG_AW  = wd_i
- wreg_o  out  1  = wreg_i
- wdata_o  out  DATA_W  selected result
- whilo_o  out  1  HI/LO write strobe
- hi_o, lo_o  out  DATA_W  HI/LO write data
- stallreq_o  out  1  hold PC/IF/ID/EX stages

## Operation
- Result classes, selected by alusel_i (default → 0):
  - LOGIC: OR, AND, XOR, NOR.
  - SHIFT: SLL, SRL, SRA. Shift amount is reg1_i[log2(DATA_W)-1:0]; the data is reg2_i.
  - ARITH: ADDU, SUBU (modulo 2^DATA_W); SLT (signed), SLTU (unsigned) → 0 or 1.
  - MOVE: MFHI → hi_i, MFLO → lo_i; MTHI/MTLO drive whilo_o=1 and copy reg1_i into the target, passing the other register through.
- Unknown aluop_i → class result 0.
- Divider FSM, registers: state, count, dividend/quotient shift register, partial remainder, divisor, sign flags.
  - IDLE: DIV/DIVU seen with annul_i=0. If divisor is 0 → DONE with q=r=0. Otherwise latch magnitudes and signs, count=0 → BUSY. stallreq_o=1 during this cycle.
  - BUSY: one restoring step per cycle, count+1; after DATA_W steps → DONE. stallreq_o=1.
  - DONE: stallreq_o=0, whilo_o=1, lo_o=quotient, hi_o=remainder. Then → IDLE.
- Signed fix-up: quotient negated if operand signs differ; remainder takes the dividend's sign. 0x80..0 / −1 yields quotient 0x80..0, remainder 0.
- annul_i=1 in any state → IDLE next edge, no whilo_o. rst has the same effect plus clears all registers.
- When rst=1: all outputs are 0 and stallreq_o=0.

## Timing
- Non-divide ops are combinational, zero latency, no registers involved.
- DIV/DIVU accepted at edge T: stallreq_o is high for cycles T..T+DATA_W (DATA_W+1 cycles). Result and whilo_o appear in cycle T+DATA_W+1.
- Divide by zero: stallreq_o is high for 1 cycle; result appears in the next cycle.
- Upstream holds aluop_i/operands stable while stallreq_o=1. Inputs are latched at acceptance, so changes during BUSY are ignored.
- Back-to-back divides: the second is accepted in the cycle after DONE.

## Configuration
- EX_MDU_DIV_EN defined: divider FSM present as above.
- EX_MDU_DIV_EN undefined: no divider registers; DIV/DIVU yield whilo_o=0 and stallreq_o=0 constantly, behaving like an unknown op.

## Structure
- The shared defines header holds the opcode and result-class constants (EXE_*_OP, EXE_RES_SHIFT/ARITH/MOVE) and the divider state encodings.
- Sub-module ex_mdu_div: the iterative signed/unsigned divider with start/annul/done handshake. It is instantiated only under EX_MDU_DIV_EN.

## Test plan
- Logic/shift: reg1=0x0000_0004, reg2=0x8000_00F0. SRA → 0xF800_000F; SRL → 0x0800_000F; OR → 0x8000_00F4.
- Arith: SUBU 0−1 → 0xFFFF_FFFF; SLT(−1,1) → 1; SLTU(0xFFFF_FFFF,1) → 0.
- DIV 7/−2 → stallreq_o high 33 cycles, then whilo_o=1, lo_o=0xFFFF_FFFD, hi_o=1. DIVU 0xFFFF_FFFF/0x10 → lo_o=0x0FFF_FFFF, hi_o=0xF.
- Divide by zero → stallreq_o 1 cycle, then whilo_o=1, hi_o=lo_o=0.
- annul_i pulsed at BUSY count 10 → stallreq_o low next cycle, no whilo_o. A new DIV then completes correctly. The same check is repeated with rst mid-divide.
- MTHI reg1=0x1234 with lo_i=0xAA → whilo_o=1, hi_o=0x1234, lo_o=0xAA; MFLO → wdata_o=0xAA.
